// File: rtl/deco_sched.sv
// Round-robin front end for the Deco turbo decoder: picks one requester's 84-bit frame,
// streams it as 21-bit start/data beats, waits for done (with watchdog) and returns a tagged result.
module deco_sched #(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk_p_i,
    input  logic                    reset_n_i,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    input  logic [NUM_REQ*84-1:0]   req_frame_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    output logic                    deco_start_o,
    output logic [20:0]             deco_data_o,
    input  logic                    deco_done_i,
    input  logic [4:0]              deco_data_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [4:0]              rsp_data_o,
    output logic [1:0]              rsp_id_o,
    output logic                    rsp_timeout_o,
    output logic                    busy_o
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, RESP} state_t;

    state_t             state, state_nx;
    logic [2:0]         beat_cnt, beat_nx;
    logic [7:0]         wd_cnt, wd_nx;
    logic [83:0]        frame_q, frame_sel;
    logic [1:0]         last_grant, id_q, grant_idx;
    logic               grant_found, do_grant;
    logic [3:0]         valid_ext;
    logic [NUM_REQ-1:0] ready_nx;
    logic               capture, capture_to;
    logic [4:0]         capture_data;
    logic [1:0]         beat_sel;
    logic [20:0]        beat_data;

    // Round-robin search starting just after the previous winner
    always_comb begin
        valid_ext = '0;
        valid_ext[NUM_REQ-1:0] = req_valid_i;
        grant_found = 1'b0;
        grant_idx = last_grant;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!grant_found && valid_ext[2'((int'(last_grant) + i) % NUM_REQ)]) begin
                grant_found = 1'b1;
                grant_idx = 2'((int'(last_grant) + i) % NUM_REQ);
            end
        end
    end

    always_comb begin
        frame_sel = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (grant_idx == 2'(r)) frame_sel = req_frame_i[r*84 +: 84];
        end
    end

    always_ff @(posedge clk_p_i or negedge reset_n_i) begin
        if (!reset_n_i) state <= IDLE;
        else            state <= state_nx;
    end

    // The accept cycle is spent in IDLE with the ready pulse out; SEND starts the cycle after.
    always_comb begin
        state_nx     = state;
        beat_nx      = beat_cnt;
        wd_nx        = wd_cnt;
        do_grant     = 1'b0;
        capture      = 1'b0;
        capture_to   = 1'b0;
        capture_data = '0;
        unique case (state)
            IDLE: begin
                if (|req_ready_o) begin
                    state_nx = SEND;
                    beat_nx  = '0;
                end else if (grant_found) begin
                    do_grant = 1'b1;
                    beat_nx  = '0;
                end
            end
            SEND: begin
                if (beat_cnt == 3'd4) begin
                    state_nx = WAIT;
                    wd_nx    = '0;
                end else begin
                    beat_nx = beat_cnt + 3'd1;
                end
            end
            WAIT: begin
                if (deco_done_i) begin
                    state_nx     = RESP;
                    capture      = 1'b1;
                    capture_data = deco_data_i;
                end else if (wd_cnt == 8'(TIMEOUT - 1)) begin
                    state_nx   = RESP;
                    capture    = 1'b1;
                    capture_to = 1'b1;
                end else begin
                    wd_nx = wd_cnt + 8'd1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_nx = IDLE;
                    do_grant = grant_found;
                    beat_nx  = '0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ready_nx = '0;
        for (int r = 0; r < NUM_REQ; r++) ready_nx[r] = do_grant && (grant_idx == 2'(r));
    end

    // Flush beat (beat_cnt 4) repeats beat 3
    always_comb begin
        beat_sel = (beat_nx > 3'd3) ? 2'd3 : beat_nx[1:0];
        unique case (beat_sel)
            2'd0:    beat_data = frame_q[20:0];
            2'd1:    beat_data = frame_q[41:21];
            2'd2:    beat_data = frame_q[62:42];
            default: beat_data = frame_q[83:63];
        endcase
    end

    always_ff @(posedge clk_p_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            beat_cnt      <= '0;
            wd_cnt        <= '0;
            frame_q       <= '0;
            id_q          <= '0;
            last_grant    <= 2'(NUM_REQ - 1);
            req_ready_o   <= '0;
            deco_start_o  <= 1'b0;
            deco_data_o   <= '0;
            rsp_valid_o   <= 1'b0;
            rsp_data_o    <= '0;
            rsp_id_o      <= '0;
            rsp_timeout_o <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            beat_cnt    <= beat_nx;
            wd_cnt      <= wd_nx;
            req_ready_o <= ready_nx;
            if (do_grant) begin
                frame_q    <= frame_sel;
                id_q       <= grant_idx;
                last_grant <= grant_idx;
            end
            deco_start_o <= (state_nx == SEND);
            if (state_nx == SEND) deco_data_o <= beat_data;
            if (capture) begin
                rsp_data_o    <= capture_data;
                rsp_timeout_o <= capture_to;
                rsp_id_o      <= id_q;
            end
            rsp_valid_o <= (state_nx == RESP);
            busy_o      <= (state_nx != IDLE);
        end
    end

endmodule

// File: tb/tb_deco_sched.sv
// Directed bench for deco_sched: responses go through an expected-queue scoreboard,
// beat/timing/handshake checks are made inline by the stimulus.
module tb_deco_sched;

    localparam int NUM_REQ = 2;
    localparam int TIMEOUT = 8;
    localparam logic [83:0] F0 = 84'h0_F2CF_F64F_83C1_9C58_6A4C;
    localparam logic [83:0] F1 = 84'h1_2345_6789_ABCD_EF01_2345;

    typedef struct packed {
        logic [4:0] data;
        logic [1:0] id;
        logic       to;
    } rsp_t;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [NUM_REQ*84-1:0] req_frame = {F1, F0};
    logic [NUM_REQ-1:0]    req_ready;
    logic                  deco_start;
    logic [20:0]           deco_data_out;
    logic                  deco_done = 1'b0;
    logic [4:0]            deco_data_in = '0;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b1;
    logic [4:0]            rsp_data;
    logic [1:0]            rsp_id;
    logic                  rsp_timeout;
    logic                  busy;

    int   errors = 0;
    int   checks = 0;
    rsp_t exp_q[$];

    deco_sched #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk_p_i      (clk),
        .reset_n_i    (reset_n),
        .req_valid_i  (req_valid),
        .req_frame_i  (req_frame),
        .req_ready_o  (req_ready),
        .deco_start_o (deco_start),
        .deco_data_o  (deco_data_out),
        .deco_done_i  (deco_done),
        .deco_data_i  (deco_data_in),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_data_o   (rsp_data),
        .rsp_id_o     (rsp_id),
        .rsp_timeout_o(rsp_timeout),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [20:0] beat(input logic [83:0] f, input int k);
        logic [83:0] t;
        t = f >> (21 * k);
        return t[20:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every response handshake must match the oldest expectation
    always @(negedge clk) begin
        if (reset_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got data=%0d id=%0d to=%0d expected none",
                         rsp_data, rsp_id, rsp_timeout);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                chk("rsp_data", 32'(rsp_data), 32'(e.data));
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
            end
        end
    end

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        deco_done = 1'b0;
        rsp_ready = 1'b1;
        tick();
        tick();
        chk("rst_outputs", {req_ready, deco_start, deco_data_out, rsp_valid, rsp_data,
                            rsp_id, rsp_timeout, busy}, 32'd0);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic wait_accept(output logic [NUM_REQ-1:0] g);
        g = '0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (req_ready != '0) begin
                g = req_ready;
                break;
            end
        end
        if (g == '0) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no req_ready expected a grant");
        end
    endtask

    // Called in accept cycle T; returns in T+6 after checking all beats
    task automatic beats_check(input logic [83:0] f, input bit spurious);
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 1) begin
                req_valid = '0;
                chk("ready_pulse", 32'(req_ready), 32'd0);
            end
            if (spurious && k == 2) begin
                deco_done    = 1'b1;
                deco_data_in = 5'd3;
            end else begin
                deco_done = 1'b0;
            end
            chk("beat_start", 32'(deco_start), 32'd1);
            chk("beat_data", 32'(deco_data_out), 32'(beat(f, (k > 4) ? 3 : k - 1)));
        end
        tick();
        chk("start_low_wait", 32'(deco_start), 32'd0);
        chk("wait_data_hold", 32'(deco_data_out), 32'(beat(f, 3)));
    endtask

    // Called in accept cycle T; done at T+6, response checked at T+7
    task automatic finish_txn(input logic [4:0] d, input logic [1:0] id,
                              input logic [NUM_REQ-1:0] drop);
        tick();
        chk("ready_pulse", 32'(req_ready), 32'd0);
        req_valid = req_valid & ~drop;
        repeat (5) tick();
        deco_done    = 1'b1;
        deco_data_in = d;
        exp_q.push_back('{data: d, id: id, to: 1'b0});
        tick();
        deco_done = 1'b0;
        chk("rsp_valid_T7", 32'(rsp_valid), 32'd1);
    endtask

    initial begin
        logic [NUM_REQ-1:0] g;

        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [NUM_REQ-1:0] g;

        // Single request, done at T+9
        do_reset();
        req_valid = 2'b01;
        wait_accept(g);
        chk("single_grant", 32'(g), 32'b01);
        chk("busy_accept", 32'(busy), 32'd0);
        beats_check(F0, 1'b0);
        repeat (3) tick();
        chk("single_no_early", 32'(rsp_valid), 32'd0);
        deco_done    = 1'b1;
        deco_data_in = 5'd19;
        exp_q.push_back('{data: 5'd19, id: 2'd0, to: 1'b0});
        tick();
        deco_done = 1'b0;
        chk("single_rsp_T10", 32'(rsp_valid), 32'd1);
        tick();
        chk("single_idle_valid", 32'(rsp_valid), 32'd0);
        chk("single_idle_busy", 32'(busy), 32'd0);

        // Round-robin with both requesters held valid
        do_reset();
        req_valid = 2'b11;
        for (int n = 0; n < 4; n++) begin
            wait_accept(g);
            chk("rr_grant", 32'(g), (n % 2 == 0) ? 32'b01 : 32'b10);
            finish_txn(5'(n + 4), 2'(n % 2), 2'b00);
        end
        req_valid = '0;
        tick();

        // Watchdog
        do_reset();
        req_valid = 2'b01;
        wait_accept(g);
        chk("wd_grant", 32'(g), 32'b01);
        tick();
        req_valid = '0;
        exp_q.push_back('{data: 5'd0, id: 2'd0, to: 1'b1});
        repeat (12) tick();
        chk("wd_no_early", 32'(rsp_valid), 32'd0);
        tick();
        chk("wd_rsp_T14", 32'(rsp_valid), 32'd1);
        chk("wd_flag", 32'(rsp_timeout), 32'd1);
        tick();
        deco_done    = 1'b1;
        deco_data_in = 5'd7;
        tick();
        deco_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("late_done_valid", 32'(rsp_valid), 32'd0);
            chk("late_done_busy", 32'(busy), 32'd0);
            tick();
        end

        // Backpressure
        do_reset();
        rsp_ready = 1'b0;
        req_valid = 2'b01;
        wait_accept(g);
        chk("bp_grant0", 32'(g), 32'b01);
        tick();
        req_valid = 2'b10;
        repeat (5) tick();
        deco_done    = 1'b1;
        deco_data_in = 5'd11;
        exp_q.push_back('{data: 5'd11, id: 2'd0, to: 1'b0});
        tick();
        deco_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_fields", {rsp_data, rsp_id, rsp_timeout}, {5'd11, 2'd0, 1'b0});
            chk("bp_busy", 32'(busy), 32'd1);
            chk("bp_no_grant", 32'(req_ready), 32'd0);
            if (i == 9) rsp_ready = 1'b1;
            else        tick();
        end
        tick();
        chk("bp_grant1", 32'(req_ready), 32'b10);
        finish_txn(5'd22, 2'd1, 2'b10);
        tick();

        // Reset in the middle of SEND
        do_reset();
        req_valid = 2'b01;
        wait_accept(g);
        tick();
        req_valid = '0;
        tick();
        tick();
        chk("mid_start_hi", 32'(deco_start), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_async_drop", {req_ready, deco_start, deco_data_out, rsp_valid, rsp_data,
                               rsp_id, rsp_timeout, busy}, 32'd0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("mid_no_rsp", {rsp_valid, busy, deco_start}, 32'd0);
        end
        req_valid = 2'b11;
        wait_accept(g);
        chk("mid_prio0", 32'(g), 32'b01);
        finish_txn(5'd9, 2'd0, 2'b11);
        tick();

        // Spurious done during SEND
        do_reset();
        req_valid = 2'b10;
        wait_accept(g);
        chk("spur_grant", 32'(g), 32'b10);
        beats_check(F1, 1'b1);
        tick();
        tick();
        chk("spur_no_early", 32'(rsp_valid), 32'd0);
        deco_done    = 1'b1;
        deco_data_in = 5'd25;
        exp_q.push_back('{data: 5'd25, id: 2'd1, to: 1'b0});
        tick();
        deco_done = 1'b0;
        chk("spur_rsp_T9", 32'(rsp_valid), 32'd1);

        repeat (4) tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
